// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback control FSM for a 32-word instruction memory.
// Optional SINGLE_STEP_EN adds a step input that launches one instruction from IDLE.
module instr_sequencer #(
  parameter logic [4:0] HALT_OP      = 5'd31,
  parameter logic [4:0] NOP_OP       = 5'd0,
  parameter int         EXEC_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [19:0] instr,
  input  logic        exec_done,
  output logic [19:0] pc,
  output logic [19:0] ir,
  output logic        exec_start,
  output logic        wb_en,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic [19:0] retired,
  output logic [2:0]  dbgState
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    FAULT  = 3'd6
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(EXEC_TIMEOUT - 1);

  state_t      state, stateNext;
  logic [19:0] pcNext, irNext, retiredNext;
  logic [7:0]  execCnt, execCntNext;
  logic        launch;

`ifdef SINGLE_STEP_EN
  assign launch = run | step;
`else
  assign launch = run;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= 20'd0;
      ir      <= 20'd0;
      retired <= 20'd0;
      execCnt <= 8'd0;
    end else begin
      state   <= stateNext;
      pc      <= pcNext;
      ir      <= irNext;
      retired <= retiredNext;
      execCnt <= execCntNext;
    end
  end

  // Handshake: exec_start pulses in the first EXEC cycle only; the unit may
  // answer with exec_done in that same cycle or any later EXEC cycle. exec_done
  // is ignored in every other state, and the FSM faults if no answer arrives.
  always_comb begin
    stateNext   = state;
    pcNext      = pc;
    irNext      = ir;
    retiredNext = retired;
    execCntNext = execCnt;
    exec_start  = 1'b0;
    wb_en       = 1'b0;
    case (state)
      IDLE: begin
        if (launch) stateNext = FETCH;
      end
      FETCH: begin
        irNext    = instr;
        stateNext = DECODE;
      end
      DECODE: begin
        if (ir[4:0] == HALT_OP) begin
          stateNext = HALT;
        end else if (ir[4:0] == NOP_OP) begin
          pcNext      = {15'd0, pc[4:0] + 5'd1};
          retiredNext = (retired == 20'hFFFFF) ? retired : retired + 20'd1;
          stateNext   = run ? FETCH : IDLE;
        end else begin
          execCntNext = 8'd0;
          stateNext   = EXEC;
        end
      end
      EXEC: begin
        exec_start = (execCnt == 8'd0);
        if (exec_done) begin
          stateNext = WB;
        end else if (execCnt == TIMEOUT_LAST) begin
          stateNext = FAULT;
        end else begin
          execCntNext = execCnt + 8'd1;
        end
      end
      WB: begin
        wb_en       = 1'b1;
        pcNext      = {15'd0, pc[4:0] + 5'd1};
        retiredNext = (retired == 20'hFFFFF) ? retired : retired + 20'd1;
        stateNext   = run ? FETCH : IDLE;
      end
      HALT:    stateNext = HALT;
      FAULT:   stateNext = FAULT;
      default: stateNext = IDLE;
    endcase
  end

  assign busy     = (state != IDLE) && (state != HALT) && (state != FAULT);
  assign halted   = (state == HALT);
  assign fault    = (state == FAULT);
  assign dbgState = state;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control FSM that drives the instruction fetch/decode datapath.
- Per instruction: generates the fetch index, latches the fetched 20-bit instruction into an instruction register, and handshakes with the selected functional unit.
- Gates the register-file write enable for exactly one cycle per retired instruction.
- Sits between the 32-word instruction memory, the decode/routing logic and the functional units.

Parameters:
- HALT_OP, 5'd31, opcode (instr[4:0]) that stops execution.
- NOP_OP, 5'd0, opcode retired without execute or writeback.
- EXEC_TIMEOUT, 16, max cycles in EXEC waiting for exec_done before FAULT (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = execute continuously.
- instr  in  20  instruction word at index pc (combinational from memory).
- exec_done  in  1  functional unit result valid on sourcesW.
- pc  out  20  fetch index; bits [19:5] always 0.
- ir  out  20  latched instruction fed to decode (opcode [4:0], A [9:5], B [14:10], W [19:15]).
- exec_start  out  1  one-cycle pulse to the functional unit.
- wb_en  out  1  one-cycle qualifier ANDed with decoded register write enables.
- busy  out  1  1 in any state except IDLE, HALT, FAULT.
- halted  out  1  sticky, HALT reached.
- fault  out  1  sticky, execute timeout.
- retired  out  20  count of retired instructions; saturates at 20'hFFFFF.

Behaviour:
- All state is updated on the rising edge of clk. rst has priority over every other input.
- Reset values: state=IDLE, pc=0, ir=0, retired=0; exec_start, wb_en, busy, halted, fault all 0.
- rst asserted mid-instruction aborts the instruction. No wb_en is issued and nothing is retired.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT, FAULT.
- IDLE: waits; run=1 -> FETCH on the next edge.
- FETCH (1 cycle): ir <= instr -> DECODE.
- DECODE (1 cycle), on ir[4:0]:
  - ==HALT_OP -> HALT. pc is not advanced; the halt is not counted as retired.
  - ==NOP_OP -> pc advances, retired increments -> FETCH if run=1, else IDLE.
  - otherwise -> EXEC; timeout counter cleared.
- EXEC:
  - exec_start=1 only in the first EXEC cycle.
  - exec_done=1 in any EXEC cycle, including the first, -> WB.
  - Each EXEC cycle without exec_done increments the counter. When EXEC_TIMEOUT cycles have elapsed without done -> FAULT.
- WB (1 cycle):
  - wb_en=1; pc advances; retired increments.
  - -> FETCH if run=1, else IDLE.
- pc advance: pc[4:0] <= pc[4:0]+1, wrapping 31 -> 0. Upper bits are held at 0.
- HALT: halted=1. FAULT: fault=1. Both are terminal; only rst exits. run and exec_done are ignored.
- run deasserted mid-instruction: the current instruction completes through WB (or NOP retire), then IDLE. run is sampled only in IDLE, WB and NOP-retire decisions.
- exec_done outside EXEC is ignored. ir is stable from DECODE through WB.
- Latency per non-NOP instruction: 4 cycles minimum (FETCH, DECODE, EXEC, WB), plus one cycle per EXEC wait.
- Latency per NOP: 2 cycles.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - IDLE leaves to FETCH on run=1 or step=1.
  - After a retire, return to IDLE unless run=1, so a step pulse with run=0 executes exactly one instruction.
  - step is ignored outside IDLE.
- Undefined: no step port; behaviour exactly as in Behaviour.

Test Plan:
- Reset/idle: assert rst 2 cycles, run=0 for 10 cycles -> pc=0, ir=0, busy=0, no exec_start or wb_en, retired=0.
- Basic retire:
  - mem[0]=20'h00C23 (op 3), run=1 from cycle 0, exec_done tied 1.
  - Expected: FETCH c1, DECODE c2, exec_start c3, wb_en c4, pc=1 after c4, retired=1.
- Wait and NOP/HALT:
  - mem[0] op 3, exec_done raised 5 cycles after exec_start; mem[1]=NOP; mem[2]=HALT_OP.
  - Expected: wb_en once; retired=2; pc=2; halted=1; busy=0; no further exec_start over 20 cycles.
- Timeout: exec_done held 0 -> fault=1 exactly EXEC_TIMEOUT cycles after exec_start; wb_en never asserted.
- Wrap/stop:
  - pc preset to 31 via program of 31 NOPs then op 3.
  - Expected: after WB pc=0.
  - run dropped during EXEC -> WB still occurs, then IDLE with busy=0.
- SINGLE_STEP_EN build: run=0, step pulse in IDLE -> exactly one instruction retired (retired 0->1), FSM returns to IDLE; rst asserted during EXEC -> next cycle all outputs at reset values.
